// File: rtl/glyph_scan_driver.sv
// Raster timing generator for a 2-clk pixel rate, plus a bouncing glyph origin
// that moves once per frame and feeds downstream letter renderers.
module glyph_scan_driver #(
   parameter int H_VIS  = 640,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_VIS  = 480,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33,
   parameter int GLYPH  = 40
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [9:0] x_init,
   input  logic [9:0] y_init,
   input  logic [3:0] vx,
   input  logic [3:0] vy,
   input  logic       move_en,
   input  logic       hide,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       pix_tick,
   output logic       frame_tick,
   output logic [9:0] x0,
   output logic [9:0] y0,
   output logic       en
);

   localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
   localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
   localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
   localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
   localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);
   localparam logic [9:0] VIS_LAST_ROW = 10'(V_VIS - 1);
   localparam logic [9:0] X_LIM    = 10'(H_VIS - GLYPH);
   localparam logic [9:0] Y_LIM    = 10'(V_VIS - GLYPH);
   localparam logic signed [10:0] X_LIM_S = 11'(H_VIS - GLYPH);
   localparam logic signed [10:0] Y_LIM_S = 11'(V_VIS - GLYPH);

   logic             pix_q;
   logic [9:0]       x_q;
   logic [9:0]       y_q;
   logic [9:0]       x0_q;
   logic [9:0]       y0_q;
   logic signed [4:0] vxr;
   logic signed [4:0] vyr;
   logic             loaded;
   logic             en_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_q <= 1'b0;
         x_q   <= '0;
         y_q   <= '0;
      end else begin
         pix_q <= ~pix_q;
         if (pix_q) begin
            if (x_q == H_LAST) begin
               x_q <= '0;
               y_q <= (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
            end else begin
               x_q <= x_q + 10'd1;
            end
         end
      end
   end

   // Sync and blanking decode straight off the counters so they never skew from x,y.
   assign x          = x_q;
   assign y          = y_q;
   assign pix_tick   = pix_q;
   assign hsync      = ~((x_q >= HS_FIRST) && (x_q <= HS_LAST));
   assign vsync      = ~((y_q >= VS_FIRST) && (y_q <= VS_LAST));
   assign video_on   = (x_q < H_VIS_C) && (y_q < V_VIS_C);
   assign frame_tick = pix_q && (x_q == H_LAST) && (y_q == VIS_LAST_ROW);

   logic signed [10:0] x_sum;
   logic signed [10:0] y_sum;
   logic [9:0]         x0_next;
   logic [9:0]         y0_next;
   logic signed [4:0]  vx_next;
   logic signed [4:0]  vy_next;

   // Bounce: clamp to the edge and reverse; 5-bit velocity makes -(-8) representable.
   always_comb begin
      x_sum   = $signed({1'b0, x0_q}) + {{6{vxr[4]}}, vxr};
      y_sum   = $signed({1'b0, y0_q}) + {{6{vyr[4]}}, vyr};
      x0_next = x_sum[9:0];
      y0_next = y_sum[9:0];
      vx_next = vxr;
      vy_next = vyr;
      if (x_sum < 11'sd0) begin
         x0_next = '0;
         vx_next = -vxr;
      end else if (x_sum > X_LIM_S) begin
         x0_next = X_LIM;
         vx_next = -vxr;
      end
      if (y_sum < 11'sd0) begin
         y0_next = '0;
         vy_next = -vyr;
      end else if (y_sum > Y_LIM_S) begin
         y0_next = Y_LIM;
         vy_next = -vyr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x0_q   <= '0;
         y0_q   <= '0;
         vxr    <= '0;
         vyr    <= '0;
         loaded <= 1'b0;
         en_q   <= 1'b0;
      end else begin
         en_q <= loaded & ~hide;
         if (load) begin
            x0_q   <= (x_init > X_LIM) ? X_LIM : x_init;
            y0_q   <= (y_init > Y_LIM) ? Y_LIM : y_init;
            vxr    <= {vx[3], vx};
            vyr    <= {vy[3], vy};
            loaded <= 1'b1;
         end else if (frame_tick && move_en) begin
            x0_q <= x0_next;
            y0_q <= y0_next;
            vxr  <= vx_next;
            vyr  <= vy_next;
         end
      end
   end

   assign x0 = x0_q;
   assign y0 = y0_q;
   assign en = en_q;

endmodule

// File: tb/tb_glyph_scan_driver.sv
// Bench for glyph_scan_driver using a reduced raster so many frames fit in a short run.
module tb_glyph_scan_driver;

   localparam int H_VIS = 40, H_FP = 2, H_SYNC = 4, H_BP = 2;
   localparam int V_VIS = 20, V_FP = 2, V_SYNC = 2, V_BP = 2;
   localparam int GLYPH = 4;
   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;   // 48
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;   // 26
   localparam int FRAME_CLK = 2 * H_TOT * V_TOT;          // 2496

   logic       clk, rst_n, load, move_en, hide;
   logic [9:0] x_init, y_init;
   logic [3:0] vx, vy;
   logic [9:0] x, y, x0, y0;
   logic       hsync, vsync, video_on, pix_tick, frame_tick, en;

   glyph_scan_driver #(
      .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .GLYPH(GLYPH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .x_init(x_init), .y_init(y_init),
      .vx(vx), .vy(vy), .move_en(move_en), .hide(hide), .x(x), .y(y),
      .hsync(hsync), .vsync(vsync), .video_on(video_on), .pix_tick(pix_tick),
      .frame_tick(frame_tick), .x0(x0), .y0(y0), .en(en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [9:0] x0;
      logic [9:0] y0;
   } exp_t;
   exp_t sb_q[$];

   // Reference raster counters.
   logic m_pt;
   int   m_x, m_y;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pt <= 1'b0; m_x <= 0; m_y <= 0;
      end else begin
         m_pt <= !m_pt;
         if (m_pt) begin
            if (m_x == H_TOT - 1) begin
               m_x <= 0;
               m_y <= (m_y == V_TOT - 1) ? 0 : m_y + 1;
            end else begin
               m_x <= m_x + 1;
            end
         end
      end
   end

   int cyc = 0, last_ft = -1, hs_low = 0;
   always @(negedge clk) begin
      logic hs_e, vs_e, vo_e, ft_e;
      if (!rst_n) begin
         last_ft = -1; hs_low = 0;
      end else begin
         cyc++;
         hs_e = !(m_x >= H_VIS + H_FP && m_x <= H_VIS + H_FP + H_SYNC - 1);
         vs_e = !(m_y >= V_VIS + V_FP && m_y <= V_VIS + V_FP + V_SYNC - 1);
         vo_e = (m_x < H_VIS) && (m_y < V_VIS);
         ft_e = m_pt && (m_x == H_TOT - 1) && (m_y == V_VIS - 1);
         check("raster", {7'd0, x, y, pix_tick, hsync, vsync, video_on, frame_tick},
               {7'd0, 10'(m_x), 10'(m_y), m_pt, hs_e, vs_e, vo_e, ft_e});
         if (frame_tick) begin
            if (last_ft >= 0) check("frame_period", cyc - last_ft, FRAME_CLK);
            last_ft = cyc;
         end
         if (!hsync) hs_low++;
         else if (hs_low > 0) begin
            check("hsync_width", hs_low, 2 * H_SYNC);
            hs_low = 0;
         end
      end
   end

   // Scoreboard monitor: compare glyph origin after each frame_tick edge with queued expectations.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && frame_tick && sb_q.size() > 0) begin
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            check("sb_x0", x0, e.x0);
            check("sb_y0", y0, e.y0);
         end
      end
   end

   task automatic push(input int ex, input int ey);
      exp_t e;
      e.x0 = 10'(ex);
      e.y0 = 10'(ey);
      sb_q.push_back(e);
   endtask

   task automatic wait_sb(input int maxc);
      int n = 0;
      while (sb_q.size() > 0 && n < maxc) begin
         @(negedge clk);
         n++;
      end
      check("sb_drain", sb_q.size(), 0);
      sb_q.delete();
   endtask

   task automatic do_load(input int xi, input int yi, input logic [3:0] vxi, input logic [3:0] vyi);
      @(negedge clk);
      load = 1'b1; x_init = 10'(xi); y_init = 10'(yi); vx = vxi; vy = vyi;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_x"}, x, 0);
      check({tag, "_y"}, y, 0);
      check({tag, "_pix"}, pix_tick, 0);
      check({tag, "_ft"}, frame_tick, 0);
      check({tag, "_x0"}, x0, 0);
      check({tag, "_y0"}, y0, 0);
      check({tag, "_en"}, en, 0);
      check({tag, "_hsync"}, hsync, 1);
      check({tag, "_vsync"}, vsync, 1);
      check({tag, "_video_on"}, video_on, 1);
   endtask

   initial begin
      int n;
      rst_n = 1'b0; load = 1'b0; move_en = 1'b0; hide = 1'b0;
      x_init = '0; y_init = '0; vx = '0; vy = '0;
      #1;
      check_reset("rst");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("pix_after_release", pix_tick, 0);
      repeat (5) @(negedge clk);
      check("en_before_load", en, 0);

      // Bounce off the right edge in x and off the top in y with vy=-8.
      move_en = 1'b1;
      push(33, 0); push(36, 8); push(29, 16); push(22, 16);
      do_load(26, 3, 4'd7, 4'b1000);
      check("load_x0", x0, 26);
      check("load_y0", y0, 3);
      @(negedge clk);
      check("en_after_load", en, 1);
      hide = 1'b1;
      #1;
      check("en_hide_same_clk", en, 1);
      @(negedge clk);
      check("en_hide_next_clk", en, 0);
      hide = 1'b0;
      @(negedge clk);
      check("en_unhide_next_clk", en, 1);
      wait_sb(5 * FRAME_CLK);

      // move_en low: origin holds.
      @(negedge clk);
      move_en = 1'b0;
      push(22, 16);
      wait_sb(2 * FRAME_CLK);

      // load on the frame_tick clk wins over motion.
      move_en = 1'b1;
      push(20, 5); push(23, 7);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_tick && n < 2 * FRAME_CLK);
      check("ft_found", frame_tick, 1);
      load = 1'b1; x_init = 10'd20; y_init = 10'd5; vx = 4'd3; vy = 4'd2;
      @(negedge clk);
      load = 1'b0;
      wait_sb(3 * FRAME_CLK);

      // Load clamps to the far edges; zero velocity holds.
      push(36, 16);
      do_load(1000, 1000, 4'd0, 4'd0);
      check("clamp_x0", x0, 36);
      check("clamp_y0", y0, 16);
      wait_sb(2 * FRAME_CLK);

      // Mid-frame asynchronous reset.
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(x == 10'd30 && y == 10'd10) && n < 2 * FRAME_CLK);
      check("reach_30_10", {x, y}, {10'd30, 10'd10});
      #2;
      rst_n = 1'b0;
      #1;
      check_reset("async_rst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("restart_x0", x, 0);
      repeat (2) @(negedge clk);
      check("restart_x1", x, 1);
      repeat (200) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/glyph_scan_driver.md
GLYPH_SCAN_DRIVER -- requirements
Module: glyph_scan_driver

Interface
REQ-001 Parameters (name, default, meaning), one per line; every REQ below uses these defaults:
- H_VIS 640: visible pixels per line
- H_FP 16: horizontal front porch
- H_SYNC 96: horizontal sync width
- H_BP 48: horizontal back porch
- V_VIS 480: visible lines
- V_FP 10: vertical front porch
- V_SYNC 2: vertical sync width
- V_BP 33: vertical back porch
- GLYPH 40: glyph cell size in pixels
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk in 1: system clock, 50 MHz
- rst_n in 1: asynchronous active-low reset
- load in 1: one-clk pulse; latch initial position and velocity
- x_init in 10: initial glyph origin x
- y_init in 10: initial glyph origin y
- vx in 4: signed x velocity, pixels/frame
- vy in 4: signed y velocity, pixels/frame
- move_en in 1: level; allow per-frame motion
- hide in 1: level; suppress en
- x out 10: current pixel column (H counter)
- y out 10: current pixel row (V counter)
- hsync out 1: active-low horizontal sync
- vsync out 1: active-low vertical sync
- video_on out 1: current x,y inside the visible area
- pix_tick out 1: one-clk strobe, every 2nd clk
- frame_tick out 1: one-clk end-of-visible-frame strobe
- x0 out 10: glyph origin x, fed to letter renderers
- y0 out 10: glyph origin y
- en out 1: glyph render enable

Function
REQ-003 pix_tick SHALL toggle every clk; it is 0 in the first clk after reset release.
REQ-004 x SHALL increment on clk edges where pix_tick=1; it wraps 799->0 and y increments on that wrap; y wraps 524->0.
REQ-005 hsync SHALL be 0 exactly for x in 656..751; vsync SHALL be 0 exactly for y in 490..491; video_on SHALL be 1 exactly for x<640 and y<480.
REQ-006 hsync, vsync and video_on SHALL describe the x,y presented in the same clk (zero skew).
REQ-007 frame_tick SHALL equal pix_tick AND x=799 AND y=479: exactly one clk per 525-line frame.
REQ-008 Internal velocities SHALL be 5-bit signed, sign-extended from vx/vy at load.
REQ-009 On load, the block SHALL set x0=min(x_init,600), y0=min(y_init,440), latch velocities and set the internal loaded flag.
REQ-010 On the frame_tick edge with move_en=1 and no load, the block SHALL set x0 to x0+vxr; if the result is <0, x0 SHALL become 0 and vxr SHALL be negated; if the result is >600, x0 SHALL become 600 and vxr SHALL be negated. y0 and vyr SHALL follow the same rule with limit 440.
REQ-011 Bounce arithmetic SHALL use at least 11-bit signed width; negating -8 SHALL give +8.
REQ-012 load coincident with frame_tick: load SHALL win and no motion SHALL apply that frame.
REQ-013 With move_en=0, x0, y0 and the velocities SHALL hold.
REQ-014 en SHALL be registered as loaded AND NOT hide, and SHALL take effect one clk after a change in hide.
REQ-015 x0 and y0 SHALL change only on load or frame_tick edges, never during the visible area.

Reset
REQ-016 When rst_n=0, the block SHALL asynchronously force x=0, y=0, pix_tick=0, frame_tick=0, x0=0, y0=0, velocities=0, loaded=0, en=0, hsync=1 and vsync=1.
REQ-017 video_on SHALL read 1 during reset, consistent with x=0, y=0.
REQ-018 A reset asserted mid-frame SHALL abort the frame; after release, counting SHALL restart at (0,0) with no spurious frame_tick.

Verification
REQ-019 Release reset and run 2 frames: x period is 1600 clk; hsync low for 192 clk per line; frame is 840000 clk; frame_tick seen once per frame.
REQ-020 load x_init=590, vx=+7, move_en=1: after 1 frame_tick x0=597; after 2, x0=600 and vxr=-7; after 3, x0=593.
REQ-021 load y_init=3, vy=-8: next frame y0=0 and vyr=+8; following frame y0=8.
REQ-022 load pulsed on the frame_tick clk with x_init=100: x0=100 afterwards, no velocity applied.
REQ-023 hide toggles mid-line: en follows one clk later; en stays 0 before any load.
REQ-024 rst_n low at x=300, y=200: all outputs reach reset values immediately without a clk edge; after release, x counts from 0.
